ahb_cache_bridge: RTL and testbench



---
 rtl/ahb_cache_bridge_if.sv | 26 ++
 rtl/ahb_cache_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_ahb_cache_bridge.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cache_bridge_if.sv
// AHB-Lite bus bundle between the CPU data port and ahb_cache_bridge.
//   master : CPU / bus side, drives address phase, write data and bus-wide hready
//   slave  : the bridge, returns hrdata, hreadyout and hresp
interface ahb_cache_bridge_if #(
    parameter int unsigned W_ADDR = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic              hready;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic              hresp;

    modport master (
        output haddr, hwrite, hsize, htrans, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, htrans, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_cache_bridge.sv
// AHB-Lite slave that turns single data-bus transfers into one-word requests on the
// cache_ctrl user port, with byte-mask generation, alignment/size error responses and
// debug counters.
// Ports:
//   clk, rst_x          clock, asynchronous active-low reset
//   ahb (slave modport) AHB-Lite bus: haddr/hwrite/hsize/htrans/hready/hwdata in,
//                       hrdata/hreadyout/hresp out
//   c_rd_en, c_wr_en    cache read / write request
//   c_addr, c_wdata     cache address and lane-aligned write data (held per request)
//   c_mask              byte enables
//   c_rdata, c_busy,    cache read data, busy and hit indication
//   c_oe
//   o_rd_cnt, o_wr_cnt  completed reads / writes
//   o_stall_cnt         cycles with hreadyout=0 and hresp=0
module ahb_cache_bridge #(
    parameter int unsigned W_ADDR    = 32,
    parameter bit          WORD_ADDR = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_x,
    ahb_cache_bridge_if.slave ahb,
    output logic             c_rd_en,
    output logic             c_wr_en,
    output logic [31:0]      c_addr,
    output logic [31:0]      c_wdata,
    output logic [3:0]       c_mask,
    input  logic [31:0]      c_rdata,
    input  logic             c_busy,
    input  logic             c_oe,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic [CNT_W-1:0] o_wr_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RD    = 4'd1;
    localparam logic [3:0] WCAP  = 4'd2;
    localparam logic [3:0] WISS  = 4'd3;
    localparam logic [3:0] WBSY  = 4'd4;
    localparam logic [3:0] WDONE = 4'd5;
    localparam logic [3:0] DONE  = 4'd6;
    localparam logic [3:0] ERR1  = 4'd7;
    localparam logic [3:0] ERR2  = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [31:0]      c_addr_q, c_addr_d;
    logic [31:0]      c_wdata_q, c_wdata_d;
    logic [3:0]       c_mask_q, c_mask_d;
    logic [3:0]       mask_q, mask_d;
    logic [31:0]      hrdata_q, hrdata_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             accept;
    logic             bad_xfer;
    logic [3:0]       new_mask;
    logic [W_ADDR-1:0] addr_conv;
    logic             ready_out;
    logic             resp_out;

    // Mask and legality of the transfer currently in its address phase.
    always_comb begin
        new_mask = 4'b0000;
        bad_xfer = 1'b0;
        unique case (ahb.hsize)
            3'd0: new_mask = 4'b0001 << ahb.haddr[1:0];
            3'd1: begin
                new_mask = 4'b0011 << ahb.haddr[1:0];
                bad_xfer = ahb.haddr[0];
            end
            3'd2: begin
                new_mask = 4'b1111;
                bad_xfer = (ahb.haddr[1:0] != 2'b00);
            end
            default: bad_xfer = 1'b1;
        endcase
    end

    always_comb begin
        if (WORD_ADDR) begin
            addr_conv = ahb.haddr >> 2;
        end else begin
            addr_conv = {ahb.haddr[W_ADDR-1:2], 2'b00};
        end
    end

    // ERR2 returns hreadyout=1, so the bus may present a new address phase there too.
    assign accept = ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR2)) &&
                    ahb.hready && ahb.htrans[1];

    always_comb begin
        ready_out = 1'b1;
        resp_out  = 1'b0;
        unique case (state_q)
            RD, WCAP, WISS, WBSY, WDONE: ready_out = 1'b0;
            ERR1: begin
                ready_out = 1'b0;
                resp_out  = 1'b1;
            end
            ERR2: resp_out = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        c_addr_d    = c_addr_q;
        c_wdata_d   = c_wdata_q;
        c_mask_d    = c_mask_q;
        mask_d      = mask_q;
        hrdata_d    = hrdata_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (!ready_out && !resp_out) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE, DONE, ERR2: begin
                if (accept) begin
                    if (bad_xfer) begin
                        state_d = ERR1;
                    end else begin
                        c_addr_d = 32'(addr_conv);
                        mask_d   = new_mask;
                        state_d  = ahb.hwrite ? WCAP : RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (!c_busy && c_oe) begin
                    hrdata_d = c_rdata;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    state_d  = DONE;
                end
            end
            WCAP: begin
                // hwdata is valid in the data phase, one cycle after the address phase.
                c_wdata_d = ahb.hwdata;
                c_mask_d  = mask_q;
                state_d   = WISS;
            end
            WISS: begin
                if (!c_busy) begin
                    state_d = WBSY;
                end
            end
            WBSY: begin
                if (c_busy) begin
                    state_d = WDONE;
                end
            end
            WDONE: begin
                if (!c_busy) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    state_d  = DONE;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q     <= IDLE;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            c_mask_q    <= '0;
            mask_q      <= '0;
            hrdata_q    <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            c_addr_q    <= c_addr_d;
            c_wdata_q   <= c_wdata_d;
            c_mask_q    <= c_mask_d;
            mask_q      <= mask_d;
            hrdata_q    <= hrdata_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Write strobe is a single cycle: it only fires in WISS when the cache is free,
    // and that same condition moves the FSM on to WBSY.
    assign c_rd_en       = (state_q == RD);
    assign c_wr_en       = (state_q == WISS) && !c_busy;
    assign c_addr        = c_addr_q;
    assign c_wdata       = c_wdata_q;
    assign c_mask        = c_mask_q;
    assign ahb.hrdata    = hrdata_q;
    assign ahb.hreadyout = ready_out;
    assign ahb.hresp     = resp_out;
    assign o_rd_cnt      = rd_cnt_q;
    assign o_wr_cnt      = wr_cnt_q;
    assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ahb_cache_bridge.sv
// Self-checking bench for ahb_cache_bridge: directed scenarios plus random transfers,
// with a behavioural cache responder and a transaction-level reference model.
module tb_ahb_cache_bridge;

    logic        clk;
    logic        rst_x;
    logic        c_rd_en;
    logic        c_wr_en;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_mask;
    logic [31:0] c_rdata;
    logic        c_busy;
    logic        c_oe;
    logic [31:0] o_rd_cnt;
    logic [31:0] o_wr_cnt;
    logic [31:0] o_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Cache responder configuration for the current transfer.
    int          cfg_lat;   // read: miss busy cycles (0 = hit); write: busy cycles
    int          cfg_pre;   // write: cycles the cache is already busy at data phase
    logic [31:0] cfg_rdata;
    bit          pre_go;
    int          rd_cyc;
    int          busy_left;

    // Reference model state.
    int          exp_rd;
    int          exp_wr;
    int          exp_stall;
    logic [31:0] exp_hrdata;

    ahb_cache_bridge_if #(.W_ADDR(32)) bus ();

    ahb_cache_bridge #(
        .W_ADDR   (32),
        .WORD_ADDR(1'b1),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .ahb        (bus),
        .c_rd_en    (c_rd_en),
        .c_wr_en    (c_wr_en),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_mask     (c_mask),
        .c_rdata    (c_rdata),
        .c_busy     (c_busy),
        .c_oe       (c_oe),
        .o_rd_cnt   (o_rd_cnt),
        .o_wr_cnt   (o_wr_cnt),
        .o_stall_cnt(o_stall_cnt)
    );

    assign bus.hready = bus.hreadyout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cache: a read miss shows one idle cycle, busy for cfg_lat cycles, then
    // a hit; a write makes the cache busy for cfg_lat cycles after the strobe.
    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rd_cyc    <= 0;
            busy_left <= 0;
        end else begin
            rd_cyc <= c_rd_en ? rd_cyc + 1 : 0;
            if (c_wr_en)             busy_left <= cfg_lat;
            else if (pre_go)         busy_left <= cfg_pre;
            else if (busy_left > 0)  busy_left <= busy_left - 1;
        end
    end

    always_comb begin
        c_busy  = (busy_left != 0) || (c_rd_en && rd_cyc >= 1 && rd_cyc <= cfg_lat);
        c_oe    = c_rd_en && (rd_cyc == ((cfg_lat == 0) ? 0 : cfg_lat + 1));
        c_rdata = cfg_rdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_rd_cnt"}, o_rd_cnt, exp_rd);
        check_eq({tag, "_wr_cnt"}, o_wr_cnt, exp_wr);
        check_eq({tag, "_stall_cnt"}, o_stall_cnt, exp_stall);
    endtask

    // Runs one transfer starting at a negedge where the bridge is ready; returns at the
    // negedge of the completion cycle (or one idle cycle after an error response).
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input int lat, input int pre,
                           input logic [31:0] rdata);
        bit          err;
        int          nbytes;
        int          exp_cyc;
        int          k;
        int          cycles;
        int          rd_cycles;
        int          wr_pulses;
        bit          addr_bad;
        bit          resp_bad;
        logic [3:0]  exp_mask;
        logic [31:0] exp_caddr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_mask;

        nbytes   = 1 << size;
        err      = (size > 3'd2) || ((addr % nbytes) != 0);
        exp_mask = 4'(((1 << nbytes) - 1) << (addr % 4));
        exp_caddr = addr >> 2;
        if (err)          exp_cyc = 1;
        else if (wr) begin
            k       = (pre + 1 > 2) ? pre + 1 : 2;
            exp_cyc = k + lat + 1;
        end else          exp_cyc = (lat == 0) ? 1 : lat + 2;

        check_eq("ready_at_addr", bus.hreadyout, 1'b1);
        cfg_lat     = lat;
        cfg_pre     = pre;
        cfg_rdata   = rdata;
        bus.haddr   = addr;
        bus.hwrite  = wr;
        bus.hsize   = size;
        bus.htrans  = 2'b10;
        pre_go      = wr;
        @(negedge clk);
        bus.htrans  = 2'b00;
        bus.hwdata  = wdata;
        pre_go      = 1'b0;

        cycles    = 0;
        rd_cycles = 0;
        wr_pulses = 0;
        addr_bad  = 1'b0;
        resp_bad  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_mask   = '0;
        while (bus.hreadyout == 1'b0 && cycles < 300) begin
            if (c_rd_en) begin
                rd_cycles++;
                if (c_addr !== exp_caddr) addr_bad = 1'b1;
            end
            if (c_wr_en) begin
                wr_pulses++;
                wr_addr = c_addr;
                wr_data = c_wdata;
                wr_mask = c_mask;
            end
            if (bus.hresp !== err) resp_bad = 1'b1;
            @(negedge clk);
            cycles++;
        end

        check_eq("wait_cycles", cycles, exp_cyc);
        check_eq("hresp_wait", resp_bad, 1'b0);
        check_eq("hresp_end", bus.hresp, err);
        check_eq("rd_en_cycles", rd_cycles, (err || wr) ? 0 : exp_cyc);
        check_eq("wr_pulses", wr_pulses, (!err && wr) ? 1 : 0);
        if (!err) begin
            if (wr) begin
                exp_wr++;
                check_eq("wr_addr", wr_addr, exp_caddr);
                check_eq("wr_data", wr_data, wdata);
                check_eq("wr_mask", wr_mask, exp_mask);
                check_eq("wr_mask_held", c_mask, exp_mask);
                check_eq("wr_data_held", c_wdata, wdata);
            end else begin
                exp_rd++;
                exp_hrdata = rdata;
                check_eq("rd_addr_stable", addr_bad, 1'b0);
            end
            exp_stall += exp_cyc;
            check_eq("c_addr_held", c_addr, exp_caddr);
        end
        check_eq("hrdata", bus.hrdata, exp_hrdata);
        check_counters("xfer");
        if (err) @(negedge clk);
    endtask

    initial begin
        rst_x       = 1'b0;
        bus.haddr   = '0;
        bus.hwrite  = 1'b0;
        bus.hsize   = 3'd0;
        bus.htrans  = 2'b00;
        bus.hwdata  = '0;
        cfg_lat     = 0;
        cfg_pre     = 0;
        cfg_rdata   = '0;
        pre_go      = 1'b0;
        exp_rd      = 0;
        exp_wr      = 0;
        exp_stall   = 0;
        exp_hrdata  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_hreadyout", bus.hreadyout, 1'b1);
        rst_x = 1'b1;
        @(negedge clk);
        check_eq("rel_hreadyout", bus.hreadyout, 1'b1);
        check_eq("rel_hresp", bus.hresp, 1'b0);
        check_eq("rel_rd_en", c_rd_en, 1'b0);
        check_eq("rel_wr_en", c_wr_en, 1'b0);
        check_eq("rel_hrdata", bus.hrdata, 32'h0);
        check_counters("rel");

        // Word read hit, then a miss with six busy cycles.
        do_xfer(1'b0, 32'h0000_0100, 3'd2, 32'h0, 0, 0, 32'hDEAD_BEEF);
        check_eq("hit_c_addr", c_addr, 32'h40);
        do_xfer(1'b0, 32'h0000_0200, 3'd2, 32'h0, 6, 0, 32'h1234_5678);

        // Byte write to the top lane.
        do_xfer(1'b1, 32'h0000_0103, 3'd0, 32'hAB00_0000, 3, 0, 32'h0);
        check_eq("byte_mask", c_mask, 4'b1000);

        // Write with the cache still busy from earlier activity.
        do_xfer(1'b1, 32'h0000_0402, 3'd1, 32'h5A5A_0000, 2, 4, 32'h0);

        // Misaligned halfword and oversize transfer.
        do_xfer(1'b0, 32'h0000_0101, 3'd1, 32'h0, 0, 0, 32'h0);
        do_xfer(1'b1, 32'h0000_0100, 3'd3, 32'hFFFF_FFFF, 1, 0, 32'h0);

        // IDLE and BUSY transfer types get zero-wait OKAY.
        bus.htrans = 2'b01;
        bus.haddr  = 32'h0000_0300;
        @(negedge clk);
        check_eq("busy_ready", bus.hreadyout, 1'b1);
        check_eq("busy_resp", bus.hresp, 1'b0);
        check_eq("busy_rd_en", c_rd_en, 1'b0);
        bus.htrans = 2'b00;
        @(negedge clk);
        check_eq("idle_ready", bus.hreadyout, 1'b1);
        check_eq("idle_rd_en", c_rd_en, 1'b0);
        check_counters("idle");

        // Randomised transfers.
        for (int i = 0; i < 40; i++) begin
            bit          r_wr;
            logic [2:0]  r_size;
            logic [31:0] r_addr;
            r_wr   = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                 : 3'($urandom_range(0, 2));
            r_addr = $urandom;
            do_xfer(r_wr, r_addr, r_size, $urandom,
                    r_wr ? $urandom_range(1, 4) : $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Back-to-back write then read, reset pulsed while the read is stalled.
        do_xfer(1'b1, 32'h0000_0010, 3'd2, 32'hCAFE_F00D, 2, 0, 32'h0);
        cfg_lat    = 6;
        cfg_rdata  = 32'h0BAD_0BAD;
        bus.haddr  = 32'h0000_0020;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.htrans = 2'b10;
        @(negedge clk);
        bus.htrans = 2'b00;
        check_eq("b2b_rd_en", c_rd_en, 1'b1);
        @(negedge clk);
        #2 rst_x = 1'b0;
        #1;
        check_eq("mid_rst_ready", bus.hreadyout, 1'b1);
        check_eq("mid_rst_resp", bus.hresp, 1'b0);
        check_eq("mid_rst_rd_en", c_rd_en, 1'b0);
        check_eq("mid_rst_wr_en", c_wr_en, 1'b0);
        check_eq("mid_rst_hrdata", bus.hrdata, 32'h0);
        check_eq("mid_rst_c_addr", c_addr, 32'h0);
        check_eq("mid_rst_c_mask", c_mask, 4'h0);
        exp_rd     = 0;
        exp_wr     = 0;
        exp_stall  = 0;
        exp_hrdata = '0;
        check_counters("mid_rst");
        @(negedge clk);
        rst_x = 1'b1;
        @(negedge clk);
        do_xfer(1'b0, 32'h0000_0020, 3'd2, 32'h0, 0, 0, 32'h7777_1111);
        check_eq("post_rst_c_addr", c_addr, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
